// File: rtl/hazard_controller.sv
// Load-use / taken-branch hazard controller: Mealy stall and flush outputs,
// a small bubble/flush sequencer and saturating stall and flush counters.
module hazard_controller #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [3:0]       ex_rd,
    input  logic             ex_mem_read_en,
    input  logic             branch_taken,
    output logic             stall,
    output logic             flush,
    output logic             pc_write_en,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2,
        BAD      = 2'd3
    } state_t;

    localparam logic [1:0] LS_INIT = 2'(LOAD_STALL_CYCLES - 1);
    localparam logic [1:0] FL_INIT = 2'(FLUSH_CYCLES - 1);

    state_t     state, state_nx;
    logic [1:0] remain, remain_nx;
    logic       stall_c, flush_c, br_acc, lu_hazard;

    assign lu_hazard = ex_mem_read_en &
                       ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                        (id_uses_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        state_nx  = state;
        remain_nx = remain;
        stall_c   = 1'b0;
        flush_c   = 1'b0;
        br_acc    = 1'b0;
        case (state)
            RUN, LU_STALL: begin
                // A taken branch wins over a hazard and aborts a pending stall.
                if (branch_taken) begin
                    flush_c = 1'b1;
                    br_acc  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_nx  = BR_FLUSH;
                        remain_nx = FL_INIT;
                    end else begin
                        state_nx  = RUN;
                        remain_nx = 2'd0;
                    end
                end else if (state == LU_STALL) begin
                    stall_c = 1'b1;
                    flush_c = 1'b1;
                    if (remain <= 2'd1) begin
                        state_nx  = RUN;
                        remain_nx = 2'd0;
                    end else begin
                        remain_nx = remain - 2'd1;
                    end
                end else if (lu_hazard) begin
                    stall_c = 1'b1;
                    flush_c = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_nx  = LU_STALL;
                        remain_nx = LS_INIT;
                    end
                end
            end
            BR_FLUSH: begin
                flush_c = 1'b1;
                if (branch_taken) begin
                    br_acc    = 1'b1;
                    remain_nx = FL_INIT;
                end else if (remain <= 2'd1) begin
                    state_nx  = RUN;
                    remain_nx = 2'd0;
                end else begin
                    remain_nx = remain - 2'd1;
                end
            end
            default: begin
                state_nx  = RUN;
                remain_nx = 2'd0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, whatever the inputs do.
    assign stall       = stall_c & ~rst;
    assign flush       = flush_c & ~rst;
    assign pc_write_en = ~stall;
    assign ctrl_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            remain       <= 2'd0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            state  <= state_nx;
            remain <= remain_nx;
            if (stall_c && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (br_acc && (flush_events != {CNT_W{1'b1}}))
                flush_events <= flush_events + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: a 2/3-cycle, 4-bit-counter instance and a
// default-parameter instance share stimulus; per-cycle expectations go through a queue.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read_en, branch_taken;

    logic        s0, f0, pc0, s1, f1, pc1;
    logic [1:0]  cs0, cs1;
    logic [3:0]  sc0, fe0;
    logic [15:0] sc1, fe1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] rs1, rs2, rd;
        logic       u1, u2, mr, bt;
    } stim_t;

    typedef struct {
        logic [9:0] v;
        string      tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    hazard_controller #(.LOAD_STALL_CYCLES(2), .FLUSH_CYCLES(3), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read_en(ex_mem_read_en), .branch_taken(branch_taken),
        .stall(s0), .flush(f0), .pc_write_en(pc0), .ctrl_state(cs0),
        .stall_cycles(sc0), .flush_events(fe0));

    hazard_controller dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
        .ex_mem_read_en(ex_mem_read_en), .branch_taken(branch_taken),
        .stall(s1), .flush(f1), .pc_write_en(pc1), .ctrl_state(cs1),
        .stall_cycles(sc1), .flush_events(fe1));

    function automatic stim_t mk_st(input logic [3:0] rs1, rs2, rd,
                                    input logic u1, u2, mr, bt);
        stim_t s;
        s.rs1 = rs1; s.rs2 = rs2; s.rd = rd;
        s.u1 = u1; s.u2 = u2; s.mr = mr; s.bt = bt;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk_st(4'd1, 4'd2, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic stim_t hz();
        return mk_st(4'd3, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    endfunction

    function automatic stim_t br();
        return mk_st(4'd1, 4'd2, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    endfunction

    function automatic stim_t hzbr();
        return mk_st(4'd3, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1);
    endfunction

    // Expected {stall, flush, pc_write_en, ctrl_state} for both instances.
    function automatic exp_t mk(input logic es0, ef0, input logic [1:0] est0,
                                input logic es1, ef1, input logic [1:0] est1,
                                input string tag);
        exp_t e;
        e.v   = {es0, ef0, ~es0, est0, es1, ef1, ~es1, est1};
        e.tag = tag;
        return e;
    endfunction

    task automatic apply(input stim_t s);
        id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
        id_uses_rs1 = s.u1; id_uses_rs2 = s.u2;
        ex_mem_read_en = s.mr; branch_taken = s.bt;
    endtask

    task automatic step(input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        apply(s);
        q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(idle());
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard: pop and compare once the cycle's outputs have settled.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [9:0] got;
            e   = q.pop_front();
            got = {s0, f0, pc0, cs0, s1, f1, pc1, cs1};
            total++;
            if (got !== e.v) begin
                bad++;
                $display("FAIL %s: got s/f/pc/st x2 = %b required %b", e.tag, got, e.v);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            id_rs1 = 4'($urandom); id_rs2 = 4'($urandom);
            ex_rd = id_rs1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'($urandom);
            ex_mem_read_en = 1'b1; branch_taken = 1'($urandom);
            @(negedge clk);
            total++;
            if ({s0, f0, pc0, cs0, s1, f1, pc1, cs1} !== 10'b00100_00100) begin
                bad++;
                $display("FAIL reset_outputs: got %b required %b",
                         {s0, f0, pc0, cs0, s1, f1, pc1, cs1}, 10'b00100_00100);
            end
            total++;
            if ({sc0, fe0, sc1, fe1} !== 40'd0) begin
                bad++;
                $display("FAIL reset_counters: got %h required 0", {sc0, fe0, sc1, fe1});
            end
        end
        rst = 1'b0;
        apply(idle());
        step(idle(), mk(0, 0, 2'd0, 0, 0, 2'd0, "reset_release"));
    endtask

    task automatic test_load_use();
        do_reset();
        step(hz(),   mk(1, 1, 2'd0, 1, 1, 2'd0, "lu_c0"));
        step(idle(), mk(1, 1, 2'd1, 0, 0, 2'd0, "lu_c1"));
        step(idle(), mk(0, 0, 2'd0, 0, 0, 2'd0, "lu_c2"));
        @(negedge clk);
        total++;
        if ({sc0, fe0, sc1, fe1} !== {4'd2, 4'd0, 16'd1, 16'd0}) begin
            bad++;
            $display("FAIL lu_counters: got %h required %h",
                     {sc0, fe0, sc1, fe1}, {4'd2, 4'd0, 16'd1, 16'd0});
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        step(mk_st(4'd5, 4'd3, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0),
             mk(0, 0, 2'd0, 0, 0, 2'd0, "nohz_unused_rs1"));
        step(mk_st(4'd7, 4'd7, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0),
             mk(0, 0, 2'd0, 0, 0, 2'd0, "nohz_not_load"));
        step(mk_st(4'd0, 4'd4, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0),
             mk(1, 1, 2'd0, 1, 1, 2'd0, "hz_reg0_rs1"));
        step(idle(), mk(1, 1, 2'd1, 0, 0, 2'd0, "hz_reg0_hold"));
        step(idle(), mk(0, 0, 2'd0, 0, 0, 2'd0, "hz_reg0_done"));
        @(negedge clk);
        total++;
        if ({sc0, sc1} !== {4'd2, 16'd1}) begin
            bad++;
            $display("FAIL nohz_counters: got %h required %h", {sc0, sc1}, {4'd2, 16'd1});
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        step(hzbr(), mk(0, 1, 2'd0, 0, 1, 2'd0, "prio_c0"));
        step(idle(), mk(0, 1, 2'd2, 0, 0, 2'd0, "prio_c1"));
        step(idle(), mk(0, 1, 2'd2, 0, 0, 2'd0, "prio_c2"));
        step(idle(), mk(0, 0, 2'd0, 0, 0, 2'd0, "prio_c3"));
        @(negedge clk);
        total++;
        if ({sc0, fe0, sc1, fe1} !== {4'd0, 4'd1, 16'd0, 16'd1}) begin
            bad++;
            $display("FAIL prio_counters: got %h required %h",
                     {sc0, fe0, sc1, fe1}, {4'd0, 4'd1, 16'd0, 16'd1});
        end
    endtask

    task automatic test_back_to_back_branch();
        do_reset();
        step(br(),   mk(0, 1, 2'd0, 0, 1, 2'd0, "b2b_c0"));
        step(br(),   mk(0, 1, 2'd2, 0, 1, 2'd0, "b2b_c1"));
        step(hz(),   mk(0, 1, 2'd2, 1, 1, 2'd0, "b2b_c2_hz_ignored"));
        step(idle(), mk(0, 1, 2'd2, 0, 0, 2'd0, "b2b_c3"));
        step(idle(), mk(0, 0, 2'd0, 0, 0, 2'd0, "b2b_c4"));
        @(negedge clk);
        total++;
        if ({sc0, fe0, sc1, fe1} !== {4'd0, 4'd2, 16'd1, 16'd2}) begin
            bad++;
            $display("FAIL b2b_counters: got %h required %h",
                     {sc0, fe0, sc1, fe1}, {4'd0, 4'd2, 16'd1, 16'd2});
        end
    endtask

    task automatic test_stall_abort();
        do_reset();
        step(hz(),   mk(1, 1, 2'd0, 1, 1, 2'd0, "abort_c0"));
        step(br(),   mk(0, 1, 2'd1, 0, 1, 2'd0, "abort_c1"));
        step(idle(), mk(0, 1, 2'd2, 0, 0, 2'd0, "abort_c2"));
        step(idle(), mk(0, 1, 2'd2, 0, 0, 2'd0, "abort_c3"));
        step(idle(), mk(0, 0, 2'd0, 0, 0, 2'd0, "abort_c4"));
        @(negedge clk);
        total++;
        if ({sc0, fe0, sc1, fe1} !== {4'd1, 4'd1, 16'd1, 16'd1}) begin
            bad++;
            $display("FAIL abort_counters: got %h required %h",
                     {sc0, fe0, sc1, fe1}, {4'd1, 4'd1, 16'd1, 16'd1});
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++)
            step(hz(), mk(1, 1, (i % 2 == 1) ? 2'd1 : 2'd0, 1, 1, 2'd0, "sat_hold"));
        step(idle(), mk(0, 0, 2'd0, 0, 0, 2'd0, "sat_done"));
        @(negedge clk);
        total++;
        if ({sc0, sc1} !== {4'd15, 16'd20}) begin
            bad++;
            $display("FAIL sat_counters: got %h required %h", {sc0, sc1}, {4'd15, 16'd20});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(hz(), mk(1, 1, 2'd0, 1, 1, 2'd0, "rmid_lu"));
        @(posedge clk);
        #1;
        apply(hz());
        rst = 1'b1;
        #1;
        total++;
        if ({s0, f0, pc0, cs0, sc0} !== {3'b001, 2'd0, 4'd0}) begin
            bad++;
            $display("FAIL rmid_lu_async: got %b required %b",
                     {s0, f0, pc0, cs0, sc0}, {3'b001, 2'd0, 4'd0});
        end
        @(negedge clk);
        rst = 1'b0;
        apply(idle());
        step(idle(), mk(0, 0, 2'd0, 0, 0, 2'd0, "rmid_lu_resume"));
        step(br(),   mk(0, 1, 2'd0, 0, 1, 2'd0, "rmid_br"));
        @(posedge clk);
        #1;
        apply(br());
        rst = 1'b1;
        #1;
        total++;
        if ({s0, f0, pc0, cs0, fe0, f1} !== {3'b001, 2'd0, 4'd0, 1'b0}) begin
            bad++;
            $display("FAIL rmid_br_async: got %b required %b",
                     {s0, f0, pc0, cs0, fe0, f1}, {3'b001, 2'd0, 4'd0, 1'b0});
        end
        @(negedge clk);
        rst = 1'b0;
        apply(idle());
        step(idle(), mk(0, 0, 2'd0, 0, 0, 2'd0, "rmid_br_resume"));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

    initial begin
        apply(idle());
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch_priority();
        test_back_to_back_branch();
        test_stall_abort();
        test_saturation();
        test_reset_mid();
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Hazard-detection and pipeline-control block that generates the `stall` and `flush` controls consumed by the IF/ID and ID/EX pipeline registers. It detects load-use hazards between the instruction in ID and a load in EX, and sequences multi-cycle bubble insertion and taken-branch flushes. It also keeps saturating performance counters for stall cycles and flush events.

## Interface
- `LOAD_STALL_CYCLES`, default 1: bubbles inserted per load-use hazard (legal 1–4).
- `FLUSH_CYCLES`, default 1: cycles `flush` is held per taken branch (legal 1–4).
- `CNT_W`, default 16: performance counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs1`, `id_rs2` in 4 each: source register numbers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the ID instruction actually reads that source.
- `ex_rd` in 4: destination register of the instruction in EX.
- `ex_mem_read_en` in 1: the EX instruction is a load.
- `branch_taken` in 1: EX resolved a taken branch this cycle.
- `stall` out 1: holds PC and IF/ID.
- `flush` out 1: clears ID/EX; also clears IF/ID when `stall`=0.
- `pc_write_en` out 1: always equals `~stall`.
- `ctrl_state` out 2: FSM state (RUN=0, LU_STALL=1, BR_FLUSH=2).
- `stall_cycles` out CNT_W: saturating count of cycles with `stall`=1.
- `flush_events` out CNT_W: saturating count of accepted taken branches.

## Operation
- `lu_hazard` = `ex_mem_read_en` & ((`id_uses_rs1` & `id_rs1`==`ex_rd`) | (`id_uses_rs2` & `id_rs2`==`ex_rd`)). Register 0 is not special.
- Outputs `stall` and `flush` are combinational (Mealy) from the state and the current inputs. A 2-bit down-counter `remain` is registered.
- **RUN**
  - `branch_taken`: `stall`=0, `flush`=1. Go to BR_FLUSH with `remain`=FLUSH_CYCLES−1 if FLUSH_CYCLES>1, else stay in RUN.
  - else `lu_hazard`: `stall`=1, `flush`=1. The front end holds and a bubble enters EX. Go to LU_STALL with `remain`=LOAD_STALL_CYCLES−1 if LOAD_STALL_CYCLES>1, else stay in RUN.
  - else: `stall`=0, `flush`=0.
  - `branch_taken` has priority over `lu_hazard` when both are asserted.
- **LU_STALL**
  - `stall`=1, `flush`=1. `lu_hazard` is not re-evaluated.
  - Decrement `remain` each cycle; when `remain`==1, the next state is RUN.
  - `branch_taken` here: `stall`=0, `flush`=1. Abort the stall and enter the RUN or BR_FLUSH path exactly as from RUN.
- **BR_FLUSH**
  - `stall`=0, `flush`=1. Decrement `remain`; when `remain`==1, go to RUN.
  - A new `branch_taken` restarts `remain` at FLUSH_CYCLES−1 and increments `flush_events`.
  - `lu_hazard` is ignored.
- Counters:
  - `stall_cycles` increments on each clock edge where `stall`=1.
  - `flush_events` increments on each edge where `branch_taken`=1 is accepted (any state).
  - Both saturate at 2^CNT_W−1 and never wrap.
- Unused state encoding 3: outputs 0, next state RUN.

## Timing
- Reset (async, immediate):
  - state=RUN, `remain`=0, counters=0.
  - While `rst`=1: `stall`=0, `flush`=0, `pc_write_en`=1, `ctrl_state`=0, regardless of inputs.
- Hazard-to-control latency is 0 cycles (same cycle, combinational). State and counters update on the rising edge.
- A load-use hazard stalls for exactly LOAD_STALL_CYCLES consecutive cycles, unless aborted by a branch.
- A taken branch flushes for exactly FLUSH_CYCLES consecutive cycles, counted from the last accepted branch.
- Reset asserted mid-LU_STALL or mid-BR_FLUSH: outputs drop to 0 asynchronously; the FSM resumes in RUN after release.

## Test plan
- **Reset**: inputs random, `rst`=1 → `stall`=0, `flush`=0, `pc_write_en`=1, counters 0. Release → `ctrl_state`=0.
- **Load-use, LOAD_STALL_CYCLES=2**: `ex_mem_read_en`=1, `ex_rd`=5, `id_rs2`=5, `id_uses_rs2`=1 → `stall`=`flush`=1 for exactly 2 cycles, then 0; `stall_cycles`=2.
- **No hazard**:
  - `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=0 → `stall`=0.
  - `ex_mem_read_en`=0 with matching registers → `stall`=0.
- **Branch priority**: `branch_taken`=1 together with a load-use hazard → `stall`=0, `flush`=1; `flush_events`=1, `stall_cycles`=0.
- **FLUSH_CYCLES=3**: branch at cycle 0 → `flush`=1 for cycles 0–2. A second branch at cycle 1 → `flush` high through cycle 3; `flush_events`=2.
- **Saturation (CNT_W=4)**: hold a hazard across 20 stall cycles → `stall_cycles` stops at 15.
